irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt initiator for the machine-mode CSR file.
- Latches rising-edge interrupt requests from peripherals and masks them with the CSR mie value.
- Picks one request by fixed priority and issues a one-cycle trap request with the matching mcause value. The pipeline uses this pulse to drive the CSR trap-write (mepc/mcause capture).
- Holds off further traps until the handler executes mret. No nesting.

Parameters:
- N_IRQ, 16, number of peripheral interrupt lines (legal range 1..16). Line i maps to mcause code 16+i and to mie bit 16+i.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- irq_req_i  in  N_IRQ  peripheral request lines, level, synchronous to clk_i
- mie_i  in  32  current mie CSR value; bit 16+i enables line i
- mret_i  in  1  one-cycle pulse, handler returned (mret retired)
- irq_o  out  1  one-cycle trap request to core/CSR
- mcause_o  out  32  cause of the most recent trap
- irq_ack_o  out  N_IRQ  one-hot acknowledge to the serviced peripheral, one cycle, coincident with irq_o
- busy_o  out  1  high while a trap is issued or being serviced

Behaviour:
- Reset (rst_ni low, asynchronous) clears everything:
  - outputs irq_o=0, mcause_o=0, irq_ack_o=0, busy_o=0
  - internal req_q=0, pending=0, state=IDLE
- Edge detect:
  - req_q <= irq_req_i every cycle.
  - edge[i] = irq_req_i[i] & ~req_q[i].
  - A line already high when reset is released produces an edge on the first clock.
- Pending register: pending[i] is set on edge[i]. It is cleared only when line i is acked (TRAP state). If set and clear happen in the same cycle, set wins and the bit stays 1.
- Masking: eligible[i] = pending[i] & mie_i[16+i]. A masked pending bit is retained and fires once unmasked.
- Priority: the lowest index among eligible lines wins.
- FSM states: IDLE, TRAP, SERVICE.
  - IDLE: if any eligible bit is set, capture the winner index into sel and go to TRAP. Otherwise stay.
  - TRAP (exactly one cycle):
    - irq_o=1; irq_ack_o bit sel set (one-hot); clear pending[sel].
    - mcause_o <= {1'b1, 31'(16+sel)}, registered so the new value is visible in the same cycle as irq_o.
    - Go to SERVICE.
  - SERVICE: wait for mret_i. On mret_i go to IDLE. Other requests keep accumulating in pending.
- irq_o, irq_ack_o and mcause_o are registered outputs (driven from flops). busy_o = (state != IDLE).
- mcause_o holds its value until the next TRAP.
- mret_i is ignored in IDLE and in TRAP.
- Latency:
  - irq_req_i rises before clock edge k → pending set at k → TRAP entered at k+1 → irq_o high during cycle k+1..k+2.
  - After mret_i sampled at edge m, the FSM is in IDLE. If a request is eligible, TRAP is entered at m+1.
- Level held high: a line held high produces one edge and therefore only one trap. A line must fall and rise again to re-request.
- mie_i changing during TRAP/SERVICE has no effect on sel or mcause_o.
- Reset mid-operation (any state) returns to IDLE immediately and discards pending requests.

Test Plan:
- Reset asserted mid-SERVICE with pending[2]=1 → all outputs 0 immediately, state IDLE, no trap after release unless a new edge occurs.
- mie_i=32'h0001_0000, irq_req_i[0] rises before edge k → irq_o=1 and irq_ack_o=16'h0001 for one cycle starting edge k+1; mcause_o=32'h8000_0010; busy_o=1 until mret_i.
- irq_req_i[5] and irq_req_i[3] rise together, mie_i=32'hFFFF_0000 → first trap mcause_o=32'h8000_0013. mret_i pulse → second trap mcause_o=32'h8000_0015 one cycle after mret_i is sampled.
- irq_req_i[4] rises with mie_i=0 → no irq_o. Later mie_i=32'h0010_0000 → trap with mcause_o=32'h8000_0014; pending bit retained while masked.
- During SERVICE, irq_req_i[1] rises; mret_i is pulsed in TRAP state earlier and ignored → exactly one trap per mret_i. Line 1 traps only after the SERVICE mret_i.
- irq_req_i[0] held high for 50 cycles → exactly one irq_o. Line falls and rises again → second trap after the mret_i.
- New edge on line sel in the same cycle as its TRAP → pending[sel] remains 1 → line retraps after mret_i.

Source files
------------

// File: rtl/irq_if.sv
// Interrupt controller bus: peripheral lines, CSR mie/mret in,
// trap request, cause and acknowledge out.
interface irq_if #(
    parameter int N_IRQ = 16
);
    logic [N_IRQ-1:0] irq_req_i;
    logic [31:0]      mie_i;
    logic             mret_i;
    logic             irq_o;
    logic [31:0]      mcause_o;
    logic [N_IRQ-1:0] irq_ack_o;
    logic             busy_o;

    modport master (
        output irq_req_i, mie_i, mret_i,
        input  irq_o, mcause_o, irq_ack_o, busy_o
    );

    modport slave (
        input  irq_req_i, mie_i, mret_i,
        output irq_o, mcause_o, irq_ack_o, busy_o
    );
endinterface

// File: rtl/irq_controller.sv
// Machine-mode interrupt initiator: edge-latched requests, mie masking,
// fixed lowest-index priority, one trap outstanding until mret.
module irq_controller #(
    parameter int N_IRQ = 16
) (
    input logic  clk_i,
    input logic  rst_ni,
    irq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        SERVICE
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] req_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] ack_q, ack_d;
    logic             irq_q, irq_d;
    logic [31:0]      mcause_q, mcause_d;
    logic             any_elig;
    logic [3:0]       win;

    assign rise = bus.irq_req_i & ~req_q;
    assign elig = pending_q & bus.mie_i[16 +: N_IRQ];

    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win      = 4'(i);
                any_elig = 1'b1;
            end
        end
    end

    // ack_q is one-hot on sel during TRAP, so it doubles as the clear mask
    assign clr       = (state_q == TRAP) ? ack_q : '0;
    assign pending_d = (pending_q & ~clr) | rise;

    always_comb begin
        state_d  = state_q;
        irq_d    = 1'b0;
        ack_d    = '0;
        mcause_d = mcause_q;
        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d  = TRAP;
                    irq_d    = 1'b1;
                    mcause_d = {1'b1, 26'd0, 1'b1, win};
                    for (int i = 0; i < N_IRQ; i++) begin
                        ack_d[i] = (win == 4'(i));
                    end
                end
            end
            TRAP: state_d = SERVICE;
            SERVICE: begin
                if (bus.mret_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            ack_q     <= '0;
            irq_q     <= 1'b0;
            mcause_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= bus.irq_req_i;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            mcause_q  <= mcause_d;
        end
    end

    assign bus.irq_o     = irq_q;
    assign bus.irq_ack_o = ack_q;
    assign bus.mcause_o  = mcause_q;
    assign bus.busy_o    = (state_q != IDLE);
endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random
// stimulus, every cycle compared against a behavioural model.
module tb_irq_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    irq_if #(.N_IRQ(16)) bus ();

    irq_controller #(.N_IRQ(16)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // behavioural model state
    bit [15:0] m_prev, m_pend, m_ack;
    bit [31:0] m_cause;
    bit        m_irq;
    bit        m_in_trap, m_busy;
    int        m_sel;
    bit [31:0] trap_log[$];

    function automatic void model_reset();
        m_prev = 0; m_pend = 0; m_ack = 0;
        m_cause = 0; m_irq = 0;
        m_in_trap = 0; m_busy = 0; m_sel = 0;
    endfunction

    function automatic void model_step(bit [15:0] r, bit [31:0] mi, bit mr);
        bit [15:0] e;
        bit [15:0] el;
        e      = r & ~m_prev;
        m_prev = r;
        m_irq  = 0;
        m_ack  = 0;
        if (m_in_trap) begin
            m_pend[m_sel] = 0;
            m_in_trap = 0;
        end else if (m_busy) begin
            if (mr) m_busy = 0;
        end else begin
            el = m_pend & mi[31:16];
            for (int i = 15; i >= 0; i--)
                if (el[i]) m_sel = i;
            if (el != 0) begin
                m_irq     = 1;
                m_ack     = 16'(1) << m_sel;
                m_cause   = 32'h8000_0010 + 32'(m_sel);
                m_in_trap = 1;
                m_busy    = 1;
            end
        end
        m_pend = m_pend | e;
    endfunction

    task automatic cyc();
        bit [15:0] r  = bus.irq_req_i;
        bit [31:0] mi = bus.mie_i;
        bit        mr = bus.mret_i;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step(r, mi, mr);
        if (bus.irq_o === 1'b1) trap_log.push_back(bus.mcause_o);
        checks++;
        if (bus.irq_o !== m_irq) begin
            errors++;
            $display("FAIL irq_o t=%0t got %b exp %b", $time, bus.irq_o, m_irq);
        end
        checks++;
        if (bus.irq_ack_o !== m_ack) begin
            errors++;
            $display("FAIL irq_ack_o t=%0t got %h exp %h",
                     $time, bus.irq_ack_o, m_ack);
        end
        checks++;
        if (bus.mcause_o !== m_cause) begin
            errors++;
            $display("FAIL mcause_o t=%0t got %h exp %h",
                     $time, bus.mcause_o, m_cause);
        end
        checks++;
        if (bus.busy_o !== (m_busy | m_in_trap)) begin
            errors++;
            $display("FAIL busy_o t=%0t got %b exp %b",
                     $time, bus.busy_o, m_busy);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_mret();
        bus.mret_i = 1'b1;
        cyc();
        bus.mret_i = 1'b0;
    endtask

    task automatic wait_trap(string name);
        int n = trap_log.size();
        for (int i = 0; i < 20 && trap_log.size() == n; i++) cyc();
        checks++;
        if (trap_log.size() == n) begin
            errors++;
            $display("FAIL %s timeout got no trap exp trap", name);
        end
    endtask

    task automatic check_log(string name, int n, bit [31:0] last);
        checks++;
        if (trap_log.size() != n ||
            (n > 0 && trap_log[n-1] !== last)) begin
            errors++;
            $display("FAIL %s got %0d traps last %h exp %0d last %h",
                     name, trap_log.size(),
                     trap_log.size() ? trap_log[$] : 32'h0, n, last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.irq_req_i = '0;
        bus.mie_i = '0;
        bus.mret_i = 1'b0;
        model_reset();
        cyc();
        run(2);
        rst_n = 1'b1;
        run(2);
    endtask

    task automatic test_single();
        bus.mie_i = 32'h0001_0000;
        bus.irq_req_i[0] = 1'b1;
        cyc();
        checks++;
        if (bus.irq_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early got %b exp 0", bus.irq_o);
        end
        cyc();
        checks++;
        if (bus.irq_o !== 1'b1 || bus.irq_ack_o !== 16'h0001 ||
            bus.mcause_o !== 32'h8000_0010) begin
            errors++;
            $display("FAIL single_trap got %b %h %h exp 1 0001 80000010",
                     bus.irq_o, bus.irq_ack_o, bus.mcause_o);
        end
        run(4);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.irq_o !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got %b/%b exp 1/0",
                     bus.busy_o, bus.irq_o);
        end
        bus.irq_req_i = '0;
        pulse_mret();
        run(2);
    endtask

    task automatic test_priority();
        trap_log.delete();
        bus.mie_i = 32'hFFFF_0000;
        bus.irq_req_i[5] = 1'b1;
        bus.irq_req_i[3] = 1'b1;
        wait_trap("prio_first");
        check_log("prio_first", 1, 32'h8000_0013);
        run(2);
        pulse_mret();
        cyc();
        checks++;
        if (bus.irq_o !== 1'b1 || bus.mcause_o !== 32'h8000_0015) begin
            errors++;
            $display("FAIL prio_second got %b %h exp 1 80000015",
                     bus.irq_o, bus.mcause_o);
        end
        run(2);
        bus.irq_req_i = '0;
        pulse_mret();
        run(2);
    endtask

    task automatic test_mask();
        trap_log.delete();
        bus.mie_i = '0;
        bus.irq_req_i[4] = 1'b1;
        run(6);
        check_log("mask_hold", 0, 32'h0);
        bus.mie_i = 32'h0010_0000;
        wait_trap("mask_release");
        check_log("mask_release", 1, 32'h8000_0014);
        bus.irq_req_i = '0;
        run(2);
        pulse_mret();
        run(2);
    endtask

    task automatic test_mret_in_trap();
        trap_log.delete();
        bus.mie_i = 32'hFFFF_0000;
        bus.irq_req_i[6] = 1'b1;
        wait_trap("mret_trap_first");
        bus.mret_i = 1'b1;
        cyc();
        bus.mret_i = 1'b0;
        bus.irq_req_i[1] = 1'b1;
        run(5);
        check_log("mret_ignored", 1, 32'h8000_0016);
        pulse_mret();
        wait_trap("mret_line1");
        check_log("mret_line1", 2, 32'h8000_0011);
        bus.irq_req_i = '0;
        run(2);
        pulse_mret();
        run(2);
    endtask

    task automatic test_level();
        trap_log.delete();
        bus.mie_i = 32'h0001_0000;
        bus.irq_req_i[0] = 1'b1;
        run(5);
        pulse_mret();
        run(44);
        check_log("level_once", 1, 32'h8000_0010);
        bus.irq_req_i[0] = 1'b0;
        cyc();
        bus.irq_req_i[0] = 1'b1;
        wait_trap("level_again");
        check_log("level_again", 2, 32'h8000_0010);
        bus.irq_req_i = '0;
        run(2);
        pulse_mret();
        run(2);
    endtask

    task automatic test_back_to_back();
        trap_log.delete();
        bus.mie_i = 32'hFFFF_0000;
        bus.irq_req_i[7] = 1'b1;
        cyc();
        bus.irq_req_i[7] = 1'b0;
        cyc();
        // new edge lands on the same edge that clears pending[7]
        bus.irq_req_i[7] = 1'b1;
        cyc();
        run(3);
        check_log("b2b_first", 1, 32'h8000_0017);
        pulse_mret();
        wait_trap("b2b_retrap");
        check_log("b2b_retrap", 2, 32'h8000_0017);
        bus.irq_req_i = '0;
        run(2);
        pulse_mret();
        run(2);
    endtask

    task automatic test_reset_mid();
        trap_log.delete();
        bus.mie_i = 32'hFFFF_0000;
        bus.irq_req_i[9] = 1'b1;
        wait_trap("rst_mid_trap");
        bus.irq_req_i[9] = 1'b0;
        cyc();
        bus.irq_req_i[2] = 1'b1;
        cyc();
        bus.irq_req_i[2] = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.irq_o !== 1'b0 || bus.irq_ack_o !== 16'h0 ||
            bus.mcause_o !== 32'h0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got %b %h %h %b exp all zero",
                     bus.irq_o, bus.irq_ack_o, bus.mcause_o, bus.busy_o);
        end
        model_reset();
        cyc();
        rst_n = 1'b1;
        run(8);
        check_log("rst_discard", 1, 32'h8000_0019);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                bus.irq_req_i ^= 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0)
                bus.mie_i = $urandom_range(0, 1) ?
                            32'hFFFF_0000 : {$urandom(), 16'h0} ;
            bus.mret_i = ($urandom_range(0, 5) == 0);
            cyc();
        end
        bus.mret_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_mret_in_trap();
        test_level();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
